// File: rtl/alu4_wide_seq.sv
// Wide-operand sequencer around a shared combinational 4-bit ALU slice.
// It runs one nibble per clock, chains both carries between slices and returns a registered wide result.
module alu4_wide_seq #(
   parameter int NIBBLES = 4,
   localparam int W = 4*NIBBLES
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [3:0]   req_op,
   input  logic [W-1:0] req_a,
   input  logic [W-1:0] req_b,
   input  logic         req_ci,
   input  logic         req_rci,
   input  logic         req_msb_first,
   input  logic         abort,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [W-1:0] rsp_y,
   output logic         rsp_co,
   output logic         rsp_rco,
   output logic         rsp_zero,
   output logic         rsp_neg,
   output logic         busy,
   output logic [3:0]   alu_op,
   output logic [3:0]   alu_a,
   output logic [3:0]   alu_b,
   output logic         alu_ci,
   output logic         alu_rci,
   input  logic [3:0]   alu_y,
   input  logic         alu_co,
   input  logic         alu_rco
);

   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IW-1:0] LAST = IW'(NIBBLES-1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                   state_q, state_d;
   logic [IW-1:0]            idx_q, idx_d;
   logic [3:0]               op_q, op_d;
   logic [NIBBLES-1:0][3:0]  a_q, a_d, b_q, b_d, y_q, y_d;
   logic                     msb_q, msb_d;
   logic                     carry_q, carry_d;
   logic                     rcarry_q, rcarry_d;
   logic                     zacc_q, zacc_d;
   logic [IW-1:0]            sel;

   assign req_ready = (state_q == IDLE) & ~abort;
   assign rsp_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign rsp_y     = y_q;
   assign rsp_co    = carry_q;
   assign rsp_rco   = rcarry_q;
   assign rsp_zero  = zacc_q;
   assign rsp_neg   = y_q[NIBBLES-1][3];

   // msb-first walks the slices top-down so right shifts carry in from above
   assign sel = msb_q ? (LAST - idx_q) : idx_q;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      y_d      = y_q;
      msb_d    = msb_q;
      carry_d  = carry_q;
      rcarry_d = rcarry_q;
      zacc_d   = zacc_q;
      alu_op   = 4'h0;
      alu_a    = 4'h0;
      alu_b    = 4'h0;
      alu_ci   = 1'b0;
      alu_rci  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid && !abort) begin
               op_d     = req_op;
               a_d      = req_a;
               b_d      = req_b;
               msb_d    = req_msb_first;
               carry_d  = req_ci;
               rcarry_d = req_rci;
               idx_d    = '0;
               zacc_d   = 1'b1;
               state_d  = RUN;
            end
         end
         RUN: begin
            alu_op   = op_q;
            alu_a    = a_q[sel];
            alu_b    = b_q[sel];
            alu_ci   = carry_q;
            alu_rci  = rcarry_q;
            y_d[sel] = alu_y;
            carry_d  = alu_co;
            rcarry_d = alu_rco;
            zacc_d   = zacc_q & (alu_y == 4'h0);
            if (idx_q == LAST) state_d = DONE;
            else               idx_d   = idx_q + 1'b1;
            if (abort) state_d = IDLE;
         end
         DONE: begin
            if (abort || rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         y_q      <= '0;
         msb_q    <= 1'b0;
         carry_q  <= 1'b0;
         rcarry_q <= 1'b0;
         zacc_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         y_q      <= y_d;
         msb_q    <= msb_d;
         carry_q  <= carry_d;
         rcarry_q <= rcarry_d;
         zacc_q   <= zacc_d;
      end
   end

endmodule

// File: tb/tb_alu4_wide_seq.sv
// Scoreboard bench for alu4_wide_seq with a behavioural ALU slice and a wide reference model.
module tb_alu4_wide_seq;
   localparam int NIB = 4;
   localparam int W   = 4*NIB;

   logic         clk = 1'b0;
   logic         rst, req_valid, req_ready, req_ci, req_rci, req_msb_first, abort;
   logic [3:0]   req_op;
   logic [W-1:0] req_a, req_b, rsp_y;
   logic         rsp_valid, rsp_ready, rsp_co, rsp_rco, rsp_zero, rsp_neg, busy;
   logic [3:0]   alu_op, alu_a, alu_b, alu_y;
   logic         alu_ci, alu_rci, alu_co, alu_rco;

   always #5 clk = ~clk;

   alu4_wide_seq #(.NIBBLES(NIB)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .req_ci(req_ci), .req_rci(req_rci),
      .req_msb_first(req_msb_first), .abort(abort), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_y(rsp_y), .rsp_co(rsp_co), .rsp_rco(rsp_rco), .rsp_zero(rsp_zero), .rsp_neg(rsp_neg),
      .busy(busy), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_ci(alu_ci),
      .alu_rci(alu_rci), .alu_y(alu_y), .alu_co(alu_co), .alu_rco(alu_rco));

   // ALU slice: op0 add with carry, op1 rotate right through rci
   always_comb begin
      alu_y   = 4'h0;
      alu_co  = 1'b0;
      alu_rco = 1'b0;
      case (alu_op)
         4'd0: {alu_co, alu_y} = {1'b0, alu_a} + {1'b0, alu_b} + 5'(alu_ci);
         4'd1: begin alu_y = {alu_rci, alu_a[3:1]}; alu_rco = alu_a[0]; end
         default: ;
      endcase
   end

   typedef struct packed {
      logic [W-1:0] y;
      logic co, rco, zero, neg;
   } exp_t;

   exp_t q[$];
   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_to(input string name);
      total++;
      bad++;
      $display("FAIL %s timed out @%0t", name, $time);
   endtask

   // Wide reference: whole-word add, or a whole-word rotate right through rci (msb-first walk)
   function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, b,
                                  input logic ci, rci);
      exp_t e;
      logic [W:0] s;
      e = '0;
      if (op == 4'd0) begin
         s     = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
         e.y   = s[W-1:0];
         e.co  = s[W];
      end else begin
         e.y   = {rci, a[W-1:1]};
         e.rco = a[0];
      end
      e.zero = (e.y == '0);
      e.neg  = e.y[W-1];
      return e;
   endfunction

   // Monitor: compare every completed response handshake against the scoreboard
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rsp_valid && rsp_ready && !abort && !rst) begin
            if (q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_rsp actual=%0h required=none", rsp_y);
            end else begin
               e = q.pop_front();
               chk("rsp_y",    32'(rsp_y),    32'(e.y));
               chk("rsp_co",   32'(rsp_co),   32'(e.co));
               chk("rsp_rco",  32'(rsp_rco),  32'(e.rco));
               chk("rsp_zero", 32'(rsp_zero), 32'(e.zero));
               chk("rsp_neg",  32'(rsp_neg),  32'(e.neg));
            end
         end
      end
   end

   // Returns #1 after the accept edge
   task automatic send(input logic [3:0] op, input logic [W-1:0] a, b,
                       input logic ci, rci, msb, input bit push);
      int n = 0;
      @(negedge clk);
      while (!req_ready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) fail_to("send");
      req_op = op; req_a = a; req_b = b; req_ci = ci; req_rci = rci; req_msb_first = msb;
      req_valid = 1'b1;
      if (push) q.push_back(model(op, a, b, ci, rci));
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_a = W'($urandom); req_b = W'($urandom); req_op = 4'($urandom); req_ci = 1'($urandom);
   endtask

   task automatic drain(input bit rnd_ready);
      int n = 0;
      while ((q.size() != 0 || busy) && n < 200) begin
         @(posedge clk); #1;
         rsp_ready = rnd_ready ? 1'($urandom) : 1'b1;
         n++;
      end
      if (n >= 200) fail_to("drain");
      rsp_ready = 1'b1;
   endtask

   initial begin
      int lat;
      logic [W-1:0] hold_y;
      logic [3:0] rot_seq [4];
      rot_seq = '{4'h8, 4'h0, 4'h0, 4'h1};
      rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_ci = 1'b0;
      req_rci = 1'b0; req_msb_first = 1'b0; abort = 1'b0; rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_y", 32'(rsp_y), 0);
      chk("rst_alu_a", 32'(alu_a), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 1);

      // carry ripple + latency (edges counted including the accept edge)
      send(4'd0, 16'h0FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1);
      lat = 1;
      while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      chk("latency", 32'(lat), 32'(NIB+1));
      drain(1'b0);

      send(4'd0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1);
      send(4'd0, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1);
      drain(1'b0);

      // wide rotate, msb-first: check slice operand order
      send(4'd1, 16'h8001, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < NIB; i++) begin
         chk("rot_alu_a", 32'(alu_a), 32'(rot_seq[i]));
         @(posedge clk); #1;
      end
      drain(1'b0);

      // response backpressure
      rsp_ready = 1'b0;
      send(4'd0, 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, 1'b1);
      lat = 0;
      while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      if (lat >= 20) fail_to("bp_valid");
      hold_y = rsp_y;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("bp_rsp_y", 32'(rsp_y), 32'(hold_y));
         chk("bp_rsp_valid", 32'(rsp_valid), 1);
         chk("bp_req_ready", 32'(req_ready), 0);
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_busy", 32'(busy), 0);
      chk("bp_release_req_ready", 32'(req_ready), 1);

      // abort on the 2nd RUN cycle
      send(4'd0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("abort_busy", 32'(busy), 0);
      lat = 0;
      for (int i = 0; i < 8; i++) begin @(negedge clk); if (rsp_valid) lat++; end
      chk("abort_no_rsp", 32'(lat), 0);
      send(4'd0, 16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b1);
      drain(1'b0);

      // reset mid-RUN
      send(4'd0, 16'h5A5A, 16'h1111, 1'b1, 1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mrst_busy", 32'(busy), 0);
      chk("mrst_rsp_valid", 32'(rsp_valid), 0);
      chk("mrst_rsp_y", 32'(rsp_y), 0);
      chk("mrst_flags", 32'({rsp_co, rsp_rco, rsp_zero, rsp_neg}), 0);
      chk("mrst_alu", 32'({alu_op, alu_a, alu_b, alu_ci, alu_rci}), 0);
      chk("mrst_req_ready", 32'(req_ready), 1);

      // randomized: adds walk lsb-first, rotates msb-first, random backpressure
      for (int i = 0; i < 40; i++) begin
         logic [3:0] op;
         op = 4'($urandom_range(0, 1));
         send(op, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), op[0], 1'b1);
         if (i % 3 == 0) drain(1'b1);
      end
      drain(1'b1);
      chk("sb_empty", 32'(q.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
